// File: rtl/seq_gen_moore.sv
// -----------------------------------------------------------------------------
// seq_gen_moore
//
// Serial pattern transmitter. Emits PATTERN MSB-first, one bit per clock, for a
// latched number of back-to-back repetitions, under a registered Moore FSM with
// a start/busy/done handshake and a graceful stop request.
//
// Optional feature (compile-time macro):
//   SEQ_GEN_PARITY_EN  - each pattern instance is followed by one even-parity
//                        bit (^PATTERN), giving a frame of PATTERN_W+1 bits.
//                        Undefined: frames are PATTERN_W bits, back-to-back.
//
// Parameters:
//   PATTERN_W   pattern length in bits (>= 2)
//   PATTERN     transmitted pattern, bit PATTERN_W-1 sent first
//   CNT_W       width of the repetition count
//
// Ports:
//   clk_i         clock, all logic on the rising edge
//   rst_ni        synchronous active-low reset
//   start_i       transmission request, sampled only in IDLE
//   reps_i        number of pattern instances, latched when start is accepted
//   stop_i        graceful stop, current instance always completes
//   out_o         serial data bit, 0 whenever out_valid_o is 0
//   out_valid_o   out_o carries a pattern or parity bit this cycle
//   busy_o        transmission in progress
//   done_o        one-cycle completion pulse after the last bit
// -----------------------------------------------------------------------------
module seq_gen_moore #(
  parameter int unsigned          PATTERN_W = 5,
  parameter logic [PATTERN_W-1:0] PATTERN   = 5'b01011,
  parameter int unsigned          CNT_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] reps_i,
  input  logic             stop_i,
  output logic             out_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IDX_W = $clog2(PATTERN_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_W - 1);

`ifdef SEQ_GEN_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd3
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             stop_pend_q, stop_pend_d;

  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             end_inst;
  logic [IDX_W-1:0] bit_sel;

  // Next-state logic.
  // NOTE: every variable written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    stop_pend_d = stop_pend_q;
    end_inst    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A zero repetition count is not a request at all.
        if (start_i && (reps_i != '0)) begin
          rem_d       = reps_i;
          idx_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = S_SEND;
        end
      end

      S_SEND: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (idx_q == LAST_IDX) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PARITY;
`else
          end_inst = 1'b1;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        if (stop_i) stop_pend_d = 1'b1;
        end_inst = 1'b1;
      end
`endif

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Instance boundary. A stop seen on this very bit still counts, so the
    // current instance is the last one. rem_q is never 0 while sending, so the
    // decrement cannot wrap.
    if (end_inst) begin
      rem_d = rem_q - CNT_W'(1);
      idx_d = '0;
      if ((rem_q == CNT_W'(1)) || stop_pend_q || stop_i) begin
        state_d = S_DONE;
      end else begin
        state_d = S_SEND;
      end
    end
  end

  // Moore outputs decoded from the next state and registered, so they line up
  // with the state they describe and carry no combinational path from inputs.
  assign bit_sel = LAST_IDX - idx_d;

  always_comb begin
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_d)
      S_SEND: begin
        out_d       = PATTERN[bit_sel];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        out_d       = ^PATTERN;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
`endif
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      stop_pend_q <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      stop_pend_q <= stop_pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_seq_gen_moore.sv
// -----------------------------------------------------------------------------
// tb_seq_gen_moore
//
// Directed testbench for seq_gen_moore. A transaction-level model tracks the
// position within the requested bit stream and predicts every output on every
// cycle; hand-written literals pin the captured bit streams and pulse counts.
// Honours SEQ_GEN_PARITY_EN for frame length and expected streams.
// -----------------------------------------------------------------------------
module tb_seq_gen_moore;

  localparam int          W     = 5;
  localparam logic [4:0]  PAT   = 5'b01011;
  localparam int          CW    = 4;
`ifdef SEQ_GEN_PARITY_EN
  localparam int          F     = W + 1;
`else
  localparam int          F     = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] reps;
  logic          stop;
  logic          out, out_valid, busy, done;

  int vectors = 0;
  int fails   = 0;

  seq_gen_moore #(.PATTERN_W(W), .PATTERN(PAT), .CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .reps_i     (reps),
    .stop_i     (stop),
    .out_o      (out),
    .out_valid_o(out_valid),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: phase 0 idle, 1 transmitting stream position m_t, 2 done pulse.
  // m_n is the number of instances that will be sent; a stop at position t
  // caps it at the instance containing t.
  // ---------------------------------------------------------------------------
  int m_phase = 0;
  int m_t     = 0;
  int m_n     = 0;

  function automatic logic frame_bit(input int j);
    if (j < W) return PAT[W-1-j];
    return ^PAT;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_t     <= 0;
    end else begin
      case (m_phase)
        0: if (start && reps != 0) begin
          m_phase <= 1;
          m_t     <= 0;
          m_n     <= int'(reps);
        end
        1: begin
          int lim;
          lim = m_n;
          if (stop && (m_t / F + 1) < lim) lim = m_t / F + 1;
          m_n <= lim;
          if (m_t + 1 >= lim * F) m_phase <= 2;
          else m_t <= m_t + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare process plus stream capture, both on the falling edge.
  logic        check_en = 1'b0;
  logic [63:0] cap      = '0;
  int          cap_len  = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (check_en) begin
      check("out_valid", 64'(out_valid), 64'(m_phase == 1));
      check("busy",      64'(busy),      64'(m_phase == 1));
      check("done",      64'(done),      64'(m_phase == 2));
      check("out",       64'(out),       64'((m_phase == 1) ? frame_bit(m_t % F) : 1'b0));
    end
    if (out_valid === 1'b1) begin
      cap     = {cap[62:0], out};
      cap_len = cap_len + 1;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    cap      = '0;
    cap_len  = 0;
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic do_start(input int n);
    reps  = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 64'(done_cnt > 0), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    reps  = CW'(2);
    stop  = 1'b0;

    // Reset held 3 cycles with start asserted.
    tick();
    check_en = 1'b1;
    tick();
    tick();
    check("rst_out",   64'({out, out_valid, busy, done}), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    clear_cap();
    repeat (4) tick();
    check("rst_no_tx", 64'(cap_len), 64'd0);

    // Single instance.
    clear_cap();
    do_start(1);
    wait_done("single", 40);
    check("single_len",  64'(cap_len),  64'(F));
`ifdef SEQ_GEN_PARITY_EN
    check("single_bits", cap, 64'b010111);
`else
    check("single_bits", cap, 64'b01011);
`endif
    check("single_done", 64'(done_cnt), 64'd1);

    // Three repetitions, back-to-back.
    clear_cap();
    do_start(3);
    wait_done("rep3", 80);
    check("rep3_len",  64'(cap_len),  64'(3 * F));
    check("rep3_busy", 64'(busy_cnt), 64'(3 * F));
`ifdef SEQ_GEN_PARITY_EN
    check("rep3_bits", cap, 64'b010111010111010111);
`else
    check("rep3_bits", cap, 64'b010110101101011);
`endif
    check("rep3_done", 64'(done_cnt), 64'd1);

    // Two repetitions.
    clear_cap();
    do_start(2);
    wait_done("rep2", 60);
`ifdef SEQ_GEN_PARITY_EN
    check("rep2_bits", cap, 64'b010111010111);
    check("rep2_len",  64'(cap_len), 64'd12);
`else
    check("rep2_bits", cap, 64'b0101101011);
    check("rep2_len",  64'(cap_len), 64'd10);
`endif

    // Stop during bit 2 of instance 2 of 4, with a start/reps change while busy.
    clear_cap();
    do_start(4);
    reps  = CW'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (F + 1) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("stop", 80);
    check("stop_len",  64'(cap_len),  64'(2 * F));
    check("stop_done", 64'(done_cnt), 64'd1);

    // Start with reps=0 is ignored.
    clear_cap();
    do_start(0);
    repeat (6) tick();
    check("zero_reps", 64'({32'(cap_len), 32'(done_cnt)}), 64'd0);

    // Stop on the final bit of the last instance changes nothing.
    clear_cap();
    do_start(1);
    repeat (F - 1) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("stop_last", 20);
    check("stop_last_len", 64'(cap_len), 64'(F));

    // Reset during instance 2 of 3, then a fresh single instance.
    clear_cap();
    do_start(3);
    repeat (F + 1) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_out", 64'({out, out_valid, busy, done}), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_nodone", 64'(done_cnt), 64'd0);
    clear_cap();
    do_start(1);
    wait_done("after_rst", 40);
`ifdef SEQ_GEN_PARITY_EN
    check("after_rst_bits", cap, 64'b010111);
`else
    check("after_rst_bits", cap, 64'b01011);
`endif
    check("after_rst_len", 64'(cap_len), 64'(F));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/seq_gen_moore.md
# seq_gen_moore

Serial pattern transmitter that emits a fixed bit sequence (default 01011) MSB-first, one bit per clock, for a requested number of back-to-back repetitions. It is the driving end of the team's serial sequence link: it produces stimulus and traffic for downstream sequence detectors. The controller is a registered Moore FSM with a start/busy/done handshake and a graceful stop request.

## Interface
- PATTERN_W, 5, pattern length in bits (≥2)
- PATTERN, 5'b01011, transmitted pattern; bit PATTERN_W-1 is sent first
- CNT_W, 4, width of repetition count
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-low
- start  in  1  request; sampled only in IDLE
- reps  in  CNT_W  pattern instances to send; latched when start is accepted
- stop  in  1  graceful stop request; honoured in SEND/PARITY
- out  out  1  serial data bit; 0 whenever out_valid=0
- out_valid  out  1  out carries a pattern or parity bit this cycle
- busy  out  1  transmission in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SEND, PARITY (only with macro), DONE.
- IDLE: start=1 and reps≠0 → latch reps, clear bit index and stop_pending, go to SEND. start=1 with reps=0 is ignored (stay IDLE, no done).
- SEND: out=PATTERN[PATTERN_W-1-idx], out_valid=1, busy=1. idx increments each cycle. At idx=PATTERN_W-1: go to PARITY if the macro is defined; otherwise end of instance.
- PARITY: out=^PATTERN (even parity), out_valid=1, busy=1; then end of instance.
- End of instance: decrement remaining count; if remaining=0 or stop_pending → DONE; else SEND with idx=0, no gap cycle.
- DONE: done=1, busy=0, out_valid=0, out=0; next state IDLE unconditionally. start in DONE is ignored.
- stop=1 in any SEND/PARITY cycle sets stop_pending. The current instance, including its parity bit, always completes. A stop in the final bit of the last instance changes nothing.
- start while busy is ignored; reps changes after acceptance have no effect.
- Bit index width: $clog2(PATTERN_W). Remaining-count width: CNT_W; no wrap-around, since the count is never decremented below 0.

## Timing
- Reset (rst=0 at clock edge): next cycle state=IDLE, out=0, out_valid=0, busy=0, done=0, counters cleared. Mid-transmission reset aborts immediately with no done pulse.
- All outputs are registered/Moore, decoded from state only; no combinational path from inputs to outputs.
- Start latency: start sampled at edge k → first bit valid from edge k+1.
- Frame length F = PATTERN_W (+1 with macro). busy and out_valid are high for exactly reps×F consecutive cycles, or (completed instances)×F after a stop.
- done is high for exactly one cycle, immediately after the last bit.
- Earliest restart: start sampled in the IDLE cycle after DONE, giving a minimum 2-cycle gap between frames of separate requests.

## Configuration
- SEQ_GEN_PARITY_EN defined: PARITY state is compiled in; each instance is followed by one even-parity bit (1 for 01011), so F=PATTERN_W+1.
- Not defined: PARITY state and parity logic are absent; F=PATTERN_W, and instances are strictly back-to-back.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 → out=0, out_valid=0, busy=0, done=0 throughout; no transmission after release unless start is reasserted.
- Single instance: reps=1, start pulse → out = 0,1,0,1,1 over 5 valid cycles, then done=1 for 1 cycle, then IDLE.
- Repetition: reps=3 → 15 contiguous valid bits 010110101101011, busy high for 15 cycles, single done pulse.
- Parity build (SEQ_GEN_PARITY_EN): reps=2 → 010111010111 (12 bits), done on cycle 13.
- Stop and ignored requests: reps=4, stop pulse during bit 2 of instance 2 → exactly 10 bits sent, then done. start during busy and start with reps=0 → no effect.
- Reset mid-operation: rst=0 during instance 2 of reps=3 → next cycle all outputs 0 with no done pulse; a fresh start with reps=1 sends 01011 correctly.
